ibex_branch_resolve_unit: RTL
=============================

IBEX_BRANCH_RESOLVE_UNIT -- requirements
Module: ibex_branch_resolve_unit

Interface
REQ-001 SHALL have parameter: Width, 32, operand/PC/target width in bits (legal 8..64).
REQ-002 SHALL have parameter: CompressedEn, 1, 1 = 16-bit instruction alignment legal; 0 = 32-bit alignment required.
REQ-003 SHALL have port: clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: in_valid_i  input  1  request valid.
REQ-006 SHALL have port: in_ready_o  output  1  unit can accept a request.
REQ-007 SHALL have port: br_op_i  input  3  000 EQ, 001 NE, 010 JAL, 011 JALR, 100 LT, 101 GE, 110 LTU, 111 GEU.
REQ-008 SHALL have ports: pc_i, rs1_i, rs2_i, imm_i  input  Width  PC, operands, sign-extended offset.
REQ-009 SHALL have port: flush_i  input  1  discard held and incoming requests.
REQ-010 SHALL have port: res_valid_o  output  1  result valid.
REQ-011 SHALL have port: res_ready_i  input  1  consumer accepts result.
REQ-012 SHALL have ports: taken_o (1), target_o (Width), misaligned_o (1)  output  resolved decision, target, alignment fault.
REQ-013 SHALL have ports: stat_clr_i input 1; stat_total_o, stat_taken_o output 32  statistics clear and counters.

Function
REQ-014 SHALL accept a request when in_valid_i && in_ready_o && !flush_i.
REQ-015 SHALL drive in_ready_o = !res_valid_o || res_ready_i (single-entry pipeline register, no combinational path from in_valid_i to res_valid_o).
REQ-016 SHALL present the result of an accepted request on the cycle after acceptance (latency 1) and hold taken_o, target_o, misaligned_o stable while res_valid_o && !res_ready_i.
REQ-017 SHALL clear res_valid_o next cycle when res_ready_i is high and no new request is accepted; accept plus consume in the same cycle SHALL load the new result with res_valid_o staying 1.
REQ-018 SHALL compute taken: EQ rs1==rs2; NE rs1!=rs2; LT/GE signed compare; LTU/GEU unsigned compare; JAL and JALR always 1.
REQ-019 SHALL compute target: JALR (rs1+imm) with bit 0 forced to 0; all others pc+imm; addition modulo 2^Width, carry discarded.
REQ-020 SHALL assert misaligned_o only when taken is 1 and target bit 1 is 1 with CompressedEn=0; misaligned_o SHALL always be 0 with CompressedEn=1.
REQ-021 SHALL register target_o for not-taken branches as well (taken_o=0 qualifies it).
REQ-022 SHALL, on flush_i, clear res_valid_o next cycle and discard any request presented that cycle; flush_i overrides res_ready_i and in_valid_i.

Reset
REQ-023 SHALL, while rst_ni is low, drive res_valid_o=0, taken_o=0, target_o=0, misaligned_o=0, stat_total_o=0, stat_taken_o=0, independent of clk_i.
REQ-024 SHALL discard an in-flight result on reset mid-operation; in_ready_o SHALL read 1 from the first cycle after reset release.

Configuration
REQ-025 SHALL, when macro BRANCH_RESOLVE_STATS_EN is defined, increment stat_total_o per consumed result (res_valid_o && res_ready_i && !flush_i) and stat_taken_o when that result has taken_o=1, both saturating at 32'hFFFF_FFFF; stat_clr_i SHALL zero both next cycle, overriding same-cycle increments.
REQ-026 SHALL, when BRANCH_RESOLVE_STATS_EN is undefined, keep all stat ports present with outputs tied to 0, no counter flops, stat_clr_i ignored.

Verification
REQ-027 SHALL cover: BLT pc=0x100, rs1=0xFFFFFFFF, rs2=1, imm=0x20 -> next cycle res_valid_o=1, taken_o=1, target_o=0x120; same with BLTU -> taken_o=0, target_o=0x120.
REQ-028 SHALL cover: JALR rs1=0x1001, imm=0x4, CompressedEn=0 -> target_o=0x1004, misaligned_o=0; JAL pc=0x200, imm=0x2 -> target_o=0x202, misaligned_o=1.
REQ-029 SHALL cover: res_ready_i=0 for 3 cycles with in_valid_i=1 -> in_ready_o=0, outputs stable; res_ready_i=1 -> new request accepted same cycle, res_valid_o stays 1.
REQ-030 SHALL cover: flush_i with res_valid_o=1 and in_valid_i=1 -> res_valid_o=0 next cycle, nothing accepted, stat counters unchanged.
REQ-031 SHALL cover: pc=0xFFFFFFFC, imm=0x8 (BEQ, equal operands) -> target_o=0x4, taken_o=1 (wrap-around).
REQ-032 SHALL cover with BRANCH_RESOLVE_STATS_EN: 5 consumed results, 3 taken -> stat_total_o=5, stat_taken_o=3; stat_clr_i with simultaneous consume -> both 0; rst_ni low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ibex_branch_resolve_unit.sv
// Branch/jump resolution stage: computes taken, target and alignment fault behind a single-entry
// valid/ready output register. Optional statistics counters are enabled by BRANCH_RESOLVE_STATS_EN.
module ibex_branch_resolve_unit #(
  parameter int unsigned Width        = 32,
  parameter bit          CompressedEn = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       br_op_i,
  input  logic [Width-1:0] pc_i,
  input  logic [Width-1:0] rs1_i,
  input  logic [Width-1:0] rs2_i,
  input  logic [Width-1:0] imm_i,
  input  logic             flush_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             taken_o,
  output logic [Width-1:0] target_o,
  output logic             misaligned_o,
  input  logic             stat_clr_i,
  output logic [31:0]      stat_total_o,
  output logic [31:0]      stat_taken_o
);

  localparam logic [2:0] OpEq   = 3'b000;
  localparam logic [2:0] OpNe   = 3'b001;
  localparam logic [2:0] OpJal  = 3'b010;
  localparam logic [2:0] OpJalr = 3'b011;
  localparam logic [2:0] OpLt   = 3'b100;
  localparam logic [2:0] OpGe   = 3'b101;
  localparam logic [2:0] OpLtu  = 3'b110;
  localparam logic [2:0] OpGeu  = 3'b111;

  logic             valid_q, valid_d;
  logic             taken_q;
  logic [Width-1:0] target_q;
  logic             mis_q;

  logic             accept_s;
  logic             eq_s, lt_s, ltu_s;
  logic             taken_s;
  logic [Width-1:0] base_s, sum_s, target_s;
  logic             mis_s;

  assign in_ready_o = !valid_q || res_ready_i;
  assign accept_s   = in_valid_i && in_ready_o && !flush_i;

  assign eq_s  = (rs1_i == rs2_i);
  assign lt_s  = ($signed(rs1_i) < $signed(rs2_i));
  assign ltu_s = (rs1_i < rs2_i);

  // Branch condition decode
  always_comb begin
    taken_s = 1'b0;
    case (br_op_i)
      OpEq:    taken_s = eq_s;
      OpNe:    taken_s = !eq_s;
      OpJal:   taken_s = 1'b1;
      OpJalr:  taken_s = 1'b1;
      OpLt:    taken_s = lt_s;
      OpGe:    taken_s = !lt_s;
      OpLtu:   taken_s = ltu_s;
      OpGeu:   taken_s = !ltu_s;
      default: taken_s = 1'b0;
    endcase
  end

  // Target adder; JALR clears bit 0 of the register-relative sum
  always_comb begin
    base_s   = (br_op_i == OpJalr) ? rs1_i : pc_i;
    sum_s    = base_s + imm_i;
    target_s = sum_s;
    if (br_op_i == OpJalr) begin
      target_s[0] = 1'b0;
    end else begin
      target_s = sum_s;
    end
  end

  // A taken target is only faulty when half-word alignment is not allowed
  always_comb begin
    mis_s = 1'b0;
    if (CompressedEn) begin
      mis_s = 1'b0;
    end else begin
      mis_s = taken_s && target_s[1];
    end
  end

  // Flush beats both consume and accept; accept beats consume
  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
    end else if (res_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Result register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept_s) begin
        taken_q  <= taken_s;
        target_q <= target_s;
        mis_q    <= mis_s;
      end
    end
  end

  assign res_valid_o  = valid_q;
  assign taken_o      = taken_q;
  assign target_o     = target_q;
  assign misaligned_o = mis_q;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic        consume_s;
  logic [31:0] total_q, total_d, tkn_q, tkn_d;

  assign consume_s = valid_q && res_ready_i && !flush_i;

  // Saturating counters; clear wins over a same-cycle increment
  always_comb begin
    total_d = total_q;
    tkn_d   = tkn_q;
    if (stat_clr_i) begin
      total_d = 32'h0000_0000;
      tkn_d   = 32'h0000_0000;
    end else if (consume_s) begin
      total_d = (total_q == 32'hFFFF_FFFF) ? total_q : total_q + 32'h0000_0001;
      tkn_d   = (taken_q && (tkn_q != 32'hFFFF_FFFF)) ? tkn_q + 32'h0000_0001 : tkn_q;
    end else begin
      total_d = total_q;
      tkn_d   = tkn_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      total_q <= 32'h0000_0000;
      tkn_q   <= 32'h0000_0000;
    end else begin
      total_q <= total_d;
      tkn_q   <= tkn_d;
    end
  end

  assign stat_total_o = total_q;
  assign stat_taken_o = tkn_q;
`else
  logic unused_stat_clr_s;
  assign unused_stat_clr_s = stat_clr_i;
  assign stat_total_o      = 32'h0000_0000;
  assign stat_taken_o      = 32'h0000_0000;
`endif

endmodule
